// File: rtl/bist_checker.sv
// bist_checker: receive-side pattern checker for a loopback self-test.
// The LFSR regenerates the sender's pattern for TEST_CASES cycles, the result
// is frozen, and after SETTLE_CYCLES the incoming channels are compared for
// CHECK_CYCLES cycles.
// Optional feature macro: BIST_CHECKER_ERRMASK_EN enables the sticky
// per-channel mismatch mask; when undefined, mismatch_mask is tied to zero.

// lfsr32: free-running 32-bit Galois LFSR (x^32 + x^22 + x^2 + x + 1).
// Holds SEED while reset is high so paired instances stay aligned.
module lfsr32 #(
  parameter logic [31:0] SEED = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rng_out
);

  logic [31:0] r_state;

  function automatic logic [31:0] f_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // Advance the sequence every cycle; reload the seed on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= SEED;
    else       r_state <= f_step(r_state);
  end

  assign rng_out = r_state;

endmodule

module bist_checker #(
  parameter int          TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int          TEST_CASES    = 1000,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          CHECK_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              error_count,
  output logic [TEST_CHANNELS-1:0] mismatch_mask
);

  typedef enum logic [1:0] {GEN, SETTLE, CHECK, DONE} state_t;

  localparam logic [31:0] LP_CASES       = 32'(TEST_CASES);
  localparam logic [31:0] LP_SETTLE_LAST = (SETTLE_CYCLES == 0) ? 32'd0 : 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] LP_CHECK_LAST  = (CHECK_CYCLES == 0) ? 32'd0 : 32'(CHECK_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [31:0]              r_case_cnt;
  logic [31:0]              w_case_nxt;
  logic [31:0]              r_phase_cnt;
  logic [TEST_CHANNELS-1:0] r_expected;
  logic [TEST_CHANNELS-1:0] w_gen_next;
  logic [15:0]              r_err;
  logic [15:0]              w_err_nxt;
  logic                     r_pass;
  logic                     w_mismatch;
  logic [31:0]              w_rng;
  logic                     w_lfsr_rst;

  // Saturating increment so a long failing run never wraps back to zero.
  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_lfsr_rst = ~reset_n;

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (w_lfsr_rst),
    .rng_out (w_rng)
  );

  // Shift the expected word left by 32 and append the new LFSR word;
  // anything beyond TEST_CHANNELS bits falls off the top.
  generate
    if (TEST_CHANNELS > 32) begin : g_wide
      assign w_gen_next = {r_expected[TEST_CHANNELS-33:0], w_rng};
    end else begin : g_narrow
      assign w_gen_next = w_rng[TEST_CHANNELS-1:0];
    end
  endgenerate

  assign w_case_nxt = r_case_cnt + 32'd1;
  assign w_mismatch = (input_channels != r_expected);
  assign w_err_nxt  = w_mismatch ? f_sat_inc(r_err) : r_err;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= GEN;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      GEN: begin
        if (w_case_nxt == LP_CASES)
          w_state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        if (r_phase_cnt == LP_SETTLE_LAST) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (r_phase_cnt == LP_CHECK_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: w_state_nxt = GEN;
    endcase
  end

  // Pattern generation, phase counting, error accumulation and verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_case_cnt  <= 32'd0;
      r_phase_cnt <= 32'd0;
      r_expected  <= '0;
      r_err       <= 16'd0;
      r_pass      <= 1'b0;
    end else begin
      if (r_state == GEN) begin
        r_case_cnt <= w_case_nxt;
        r_expected <= w_gen_next;
      end
      if (w_state_nxt != r_state)
        r_phase_cnt <= 32'd0;
      else if (r_state == SETTLE || r_state == CHECK)
        r_phase_cnt <= r_phase_cnt + 32'd1;
      if (r_state == CHECK)
        r_err <= w_err_nxt;
      if (r_state == CHECK && w_state_nxt == DONE)
        r_pass <= (w_err_nxt == 16'd0);
    end
  end

`ifdef BIST_CHECKER_ERRMASK_EN
  logic [TEST_CHANNELS-1:0] r_mask;

  // Sticky record of every channel that ever mismatched during CHECK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_mask <= '0;
    else if (r_state == CHECK) r_mask <= r_mask | (input_channels ^ r_expected);
  end

  assign mismatch_mask = r_mask;
`else
  assign mismatch_mask = '0;
`endif

  assign pass        = r_pass;
  assign error_count = r_err;

endmodule

// File: tb/tb_bist_checker.sv
// Directed bench for bist_checker: loopback runs from a vector table, a
// mid-CHECK reset abort, and a saturation run on a second instance.
module tb_bist_checker;

  localparam int T   = 1000;
  localparam int S   = 4;
  localparam int C   = 16;
  localparam int TOT = T + S + C;

  localparam int ST  = 2;
  localparam int SC  = 70000;
  localparam int STOT = ST + SC;

`ifdef BIST_CHECKER_ERRMASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [69:0] in_ch;
  logic        busy, done, pass;
  logic [15:0] err;
  logic [69:0] mask;

  logic        reset_n_s;
  logic [69:0] in_s;
  logic        busy_s, done_s, pass_s;
  logic [15:0] err_s;
  logic [69:0] mask_s;

  int checks;
  int failures;

  logic [69:0] exp_main;
  logic [69:0] exp_sat;

  typedef struct {
    logic [69:0] flip;
    int          first;
    int          last;
    logic [15:0] err;
    logic        pass;
    logic [69:0] mask;
  } vec_t;

  vec_t vecs[6];

  bist_checker #(
    .TEST_CHANNELS(70), .SEED(32'hdeadbeef), .TEST_CASES(T),
    .SETTLE_CYCLES(S), .CHECK_CYCLES(C)
  ) dut (
    .clk(clk), .reset_n(reset_n), .input_channels(in_ch),
    .busy(busy), .done(done), .pass(pass),
    .error_count(err), .mismatch_mask(mask)
  );

  bist_checker #(
    .TEST_CHANNELS(70), .SEED(32'hdeadbeef), .TEST_CASES(ST),
    .SETTLE_CYCLES(0), .CHECK_CYCLES(SC)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n_s), .input_channels(in_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .error_count(err_s), .mismatch_mask(mask_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR step: Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ ({32{s[0]}} & 32'h80200003);
  endfunction

  // Expected word after n generation cycles for a 70-channel checker.
  function automatic logic [69:0] ref_expected(input int n);
    logic [31:0] s;
    logic [69:0] e;
    s = 32'hdeadbeef;
    e = '0;
    for (int i = 0; i < n; i++) begin
      e = {e[37:0], s};
      s = ref_step(s);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},  {127'd0, busy}, 128'd1);
    chk({tag, "_done"},  {127'd0, done}, 128'd0);
    chk({tag, "_pass"},  {127'd0, pass}, 128'd0);
    chk({tag, "_err"},   {112'd0, err},  128'd0);
    chk({tag, "_mask"},  {58'd0, mask},  128'd0);
  endtask

  task automatic main_seq();
    logic [69:0] f;
    int j;
    // Table-driven loopback runs.
    for (int v = 0; v < 6; v++) begin
      reset_n = 1'b0;
      in_ch   = exp_main;
      repeat (2) @(negedge clk);
      chk_reset_state($sformatf("v%0d_rst", v));
      reset_n = 1'b1;
      for (int n = 1; n <= TOT; n++) begin
        j = n - 1 - T - S;
        f = (j >= vecs[v].first && j <= vecs[v].last) ? vecs[v].flip : 70'd0;
        in_ch = exp_main ^ f;
        @(posedge clk);
        @(negedge clk);
        if (n == TOT - 1) begin
          chk($sformatf("v%0d_done_early", v), {127'd0, done}, 128'd0);
          chk($sformatf("v%0d_pass_early", v), {127'd0, pass}, 128'd0);
        end
      end
      chk($sformatf("v%0d_done", v), {127'd0, done}, 128'd1);
      chk($sformatf("v%0d_busy", v), {127'd0, busy}, 128'd0);
      chk($sformatf("v%0d_err", v),  {112'd0, err},  {112'd0, vecs[v].err});
      chk($sformatf("v%0d_pass", v), {127'd0, pass}, {127'd0, vecs[v].pass});
      chk($sformatf("v%0d_mask", v), {58'd0, mask},  {58'd0, MASK_ON ? vecs[v].mask : 70'd0});
      // DONE is terminal and frozen even with garbage on the channels.
      in_ch = ~exp_main;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_hold_done", v), {127'd0, done}, 128'd1);
      chk($sformatf("v%0d_hold_err", v),  {112'd0, err},  {112'd0, vecs[v].err});
    end

    // Failing run aborted by reset at the 8th check cycle, then a clean run.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= T + S + 8; n++) begin
      j = n - 1 - T - S;
      in_ch = (j >= 0) ? (exp_main ^ (70'd1 << 5)) : exp_main;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_err_before", {112'd0, err}, 128'd8);
    reset_n = 1'b0;
    #1;
    chk_reset_state("abort_rst");
    @(negedge clk);
    reset_n = 1'b1;
    in_ch = exp_main;
    for (int n = 1; n <= TOT; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == TOT - 1) chk("rerun_done_early", {127'd0, done}, 128'd0);
    end
    chk("rerun_done", {127'd0, done}, 128'd1);
    chk("rerun_pass", {127'd0, pass}, 128'd1);
    chk("rerun_err",  {112'd0, err},  128'd0);
    chk("rerun_mask", {58'd0, mask},  128'd0);
  endtask

  task automatic sat_seq();
    in_s = ~exp_sat;
    repeat (2) @(negedge clk);
    chk("sat_rst_err", {112'd0, err_s}, 128'd0);
    reset_n_s = 1'b1;
    for (int n = 1; n <= STOT; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == ST + 1)     chk("sat_first_check", {112'd0, err_s}, 128'd1);
      if (n == ST + 65535) chk("sat_reach",       {112'd0, err_s}, 128'd65535);
      if (n == ST + 65537) chk("sat_no_wrap",     {112'd0, err_s}, 128'd65535);
      if (n == STOT - 1)   chk("sat_done_early",  {127'd0, done_s}, 128'd0);
    end
    chk("sat_done", {127'd0, done_s}, 128'd1);
    chk("sat_err",  {112'd0, err_s},  128'd65535);
    chk("sat_pass", {127'd0, pass_s}, 128'd0);
    chk("sat_mask", {58'd0, mask_s},  {58'd0, MASK_ON ? {70{1'b1}} : 70'd0});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    reset_n_s = 1'b0;
    exp_main  = ref_expected(T);
    exp_sat   = ref_expected(ST);
    in_ch     = '0;
    in_s      = '0;

    vecs[0] = '{flip: 70'd0,            first: 0,  last: 15, err: 16'd0,  pass: 1'b1, mask: 70'd0};
    vecs[1] = '{flip: 70'd1 << 5,       first: 0,  last: 15, err: 16'd16, pass: 1'b0, mask: 70'd1 << 5};
    vecs[2] = '{flip: (70'd1 << 69) | 70'd1, first: 2, last: 2, err: 16'd1, pass: 1'b0, mask: (70'd1 << 69) | 70'd1};
    vecs[3] = '{flip: {70{1'b1}},       first: 0,  last: 3,  err: 16'd4,  pass: 1'b0, mask: {70{1'b1}}};
    vecs[4] = '{flip: 70'd1 << 69,      first: 15, last: 15, err: 16'd1,  pass: 1'b0, mask: 70'd1 << 69};
    vecs[5] = '{flip: {70{1'b1}},       first: -4, last: -1, err: 16'd0,  pass: 1'b1, mask: 70'd0};

    fork
      main_seq();
      sat_seq();
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_checker.md
BIST_CHECKER -- requirements
Module: bist_checker

Interface
REQ-001 Parameter TEST_CHANNELS, default 70: width of the checked channel bus.
REQ-002 Parameter SEED, default 32'hdeadbeef: LFSR seed; SHALL equal the paired sender's seed.
REQ-003 Parameter TEST_CASES, default 1000: pattern-generation cycles; SHALL equal the paired sender's value.
REQ-004 Parameter SETTLE_CYCLES, default 4: cycles ignored after generation before sampling.
REQ-005 Parameter CHECK_CYCLES, default 16: number of compared cycles.
REQ-006 Port clk, input, 1: sole clock; all state on rising edge.
REQ-007 Port reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port input_channels, input, TEST_CHANNELS: channels received from the sender through the network under test.
REQ-009 Port busy, output, 1: high in any state other than DONE.
REQ-010 Port done, output, 1: high in DONE.
REQ-011 Port pass, output, 1: valid when done; high iff error_count is 0.
REQ-012 Port error_count, output, 16: number of mismatching check cycles, saturating.
REQ-013 Port mismatch_mask, output, TEST_CHANNELS: sticky per-channel mismatch flags.

Function
REQ-014 The block SHALL instantiate lfsr32 with SEED, clk, and reset driven by ~reset_n, so its sequence aligns with a sender released from reset in the same cycle.
REQ-015 FSM states SHALL be GEN, SETTLE, CHECK, DONE, with GEN as the reset state.
REQ-016 GEN SHALL last exactly TEST_CASES cycles, counted by a 32-bit case counter starting at 0.
- Each GEN cycle: expected <= (expected << 32) | zero-extended rng_out, truncated to TEST_CHANNELS bits.
REQ-017 GEN -> SETTLE SHALL occur on the cycle the case counter reaches TEST_CASES; expected SHALL be frozen from then on.
REQ-018 SETTLE SHALL last SETTLE_CYCLES cycles with no comparison.
- SETTLE_CYCLES = 0 SHALL go directly to CHECK.
REQ-019 CHECK SHALL last CHECK_CYCLES cycles; each cycle compares input_channels to expected.
- On any mismatch, error_count increments by 1, saturating at 16'hFFFF.
REQ-020 CHECK -> DONE SHALL occur after the final check cycle; DONE is terminal until reset.
REQ-021 error_count and mismatch_mask SHALL be stable in DONE; pass = (error_count == 0) registered on entry to DONE, and 0 before DONE.
REQ-022 Total latency from reset release to done = 1 SHALL be TEST_CASES + SETTLE_CYCLES + CHECK_CYCLES cycles.
REQ-023 For TEST_CHANNELS < 32, only the low TEST_CHANNELS bits of rng_out SHALL contribute.
- Bits shifted beyond TEST_CHANNELS SHALL be discarded.

Reset
REQ-024 While reset_n = 0 the block SHALL hold:
- state = GEN, case counter = 0, expected = 0
- busy = 1, done = 0, pass = 0
- error_count = 0, mismatch_mask = 0
REQ-025 Reset asserted in any state, including mid-CHECK, SHALL abort immediately and restart generation from case 0 on release, with no counts retained.

Configuration
REQ-026 Macro BIST_CHECKER_ERRMASK_EN defined: during CHECK, each cycle mismatch_mask |= input_channels ^ expected.
REQ-027 Macro BIST_CHECKER_ERRMASK_EN undefined: mismatch_mask SHALL be tied to 0, with no mask register synthesized; all other behaviour is unchanged.

Verification
REQ-028 Sender (TEST_CASES = 1000) looped back into the checker, both released together:
-> done rises at cycle 1020; pass = 1, error_count = 0, mismatch_mask = 0.
REQ-029 Loopback with channel bit 5 inverted throughout CHECK, macro defined:
-> error_count = 16, pass = 0, mismatch_mask = 1 << 5.
REQ-030 Loopback with bits 0 and 69 inverted for only the third check cycle:
-> error_count = 1, mismatch_mask has bits 0 and 69 set.
REQ-031 CHECK_CYCLES = 70000 with constant mismatch:
-> error_count saturates at 65535 and does not wrap; pass = 0.
REQ-032 reset_n pulsed low at the 8th CHECK cycle of a failing run, then a clean loopback:
-> all outputs return to reset values; the next run completes with pass = 1 at 1020 cycles after release.
REQ-033 Macro undefined, bit 5 inverted:
-> error_count = 16, mismatch_mask = 0.
